// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage integer unit with a valid/ready handshake.
// Base ALU ops finish in one cycle. RV32M multiply/divide/remainder run a
// 1-bit-per-cycle shift datapath on operand magnitudes; the result sign is
// applied in a single FIX cycle before the result is presented in DONE.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      opcode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] d
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // XLEN is a power of two, so the last step index is all ones.
  localparam logic [CW-1:0] LAST_STEP = {CW{1'b1}};

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_is_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_bzero;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_d;
  logic              r_valid;

  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_rem_diff;
  logic              w_rem_ge;
  logic [XLEN-1:0]   w_hi_nx;
  logic [XLEN-1:0]   w_lo_nx;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  // Single-cycle base ALU: op[2:0] selects the function, op[3] picks sub / arithmetic shift.
  function automatic logic [XLEN-1:0] alu_base(input logic [3:0] op,
                                                input logic [XLEN-1:0] x,
                                                input logic [XLEN-1:0] y);
    logic [CW-1:0]   sh;
    logic [XLEN-1:0] res;
    sh = y[CW-1:0];
    case (op[2:0])
      3'd0: res = op[3] ? (x - y) : (x + y);
      3'd1: res = x << sh;
      3'd2: res = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      3'd3: res = {{(XLEN-1){1'b0}}, (x < y)};
      3'd4: res = x ^ y;
      3'd5: begin
        if (op[3]) res = $signed(x) >>> sh;
        else       res = x >> sh;
      end
      3'd6: res = x | y;
      3'd7: res = x & y;
      default: res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  // Operand signs for the M op being requested, and the magnitudes fed to the datapath.
  always_comb begin
    w_sa = a[XLEN-1] & ((opcode[2:0] == 3'd1) | (opcode[2:0] == 3'd2) |
                        (opcode[2:0] == 3'd4) | (opcode[2:0] == 3'd6));
    w_sb = b[XLEN-1] & ((opcode[2:0] == 3'd1) | (opcode[2:0] == 3'd4) |
                        (opcode[2:0] == 3'd6));
    w_mag_a = w_sa ? (-a) : a;
    w_mag_b = w_sb ? (-b) : b;
  end

  // One iteration: shift-add multiply ({hi,lo} >> 1) or restoring divide ({hi,lo} << 1).
  always_comb begin
    w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    w_rem_sh   = {r_hi, r_lo[XLEN-1]};
    w_rem_ge   = (w_rem_sh >= {1'b0, r_opnd});
    w_rem_diff = w_rem_sh - {1'b0, r_opnd};
    if (r_is_div) begin
      w_hi_nx = w_rem_ge ? w_rem_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
      w_lo_nx = {r_lo[XLEN-2:0], w_rem_ge};
    end else begin
      w_hi_nx = w_sum[XLEN:1];
      w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Sign fix-up and result select; a zero divisor forces an all-ones quotient.
  always_comb begin
    w_prod = r_neg_q ? (-{r_hi, r_lo}) : {r_hi, r_lo};
    w_quot = r_bzero ? {XLEN{1'b1}} : (r_neg_q ? (-r_lo) : r_lo);
    w_rem  = r_neg_r ? (-r_hi) : r_hi;
    case (r_op)
      3'd0:                w_fix_res = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          w_fix_res = w_quot;
      3'd6, 3'd7:          w_fix_res = w_rem;
      default:             w_fix_res = {XLEN{1'b0}};
    endcase
  end

  // Control FSM and datapath registers; reset dominates kill, kill dominates everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_op     <= 3'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bzero  <= 1'b0;
      r_hi     <= {XLEN{1'b0}};
      r_lo     <= {XLEN{1'b0}};
      r_opnd   <= {XLEN{1'b0}};
      r_d      <= {XLEN{1'b0}};
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!kill && in_valid) begin
            if (!opcode[4]) begin
              r_d     <= alu_base(opcode[3:0], a, b);
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_op     <= opcode[2:0];
              r_is_div <= opcode[2];
              r_neg_q  <= w_sa ^ w_sb;
              r_neg_r  <= w_sa;
              r_bzero  <= (b == {XLEN{1'b0}});
              r_cnt    <= {CW{1'b0}};
              r_hi     <= {XLEN{1'b0}};
              r_lo     <= opcode[2] ? w_mag_a : w_mag_b;
              r_opnd   <= opcode[2] ? w_mag_b : w_mag_a;
              r_state  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (kill) begin
            r_cnt   <= {CW{1'b0}};
            r_state <= S_IDLE;
          end else begin
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (r_cnt == LAST_STEP) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (kill) begin
            r_state <= S_IDLE;
          end else begin
            r_d     <= w_fix_res;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (kill || out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_valid;
  assign d         = r_d;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: scoreboard bench for alu_mdu at XLEN=32 (directed + random)
// and XLEN=8 (random). Expected results are queued when a request is driven
// and compared when the unit presents out_valid.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset, kill, out_ready;
  logic [4:0]  opcode;
  logic [31:0] a, b;
  logic        in_valid32, in_ready32, out_valid32;
  logic [31:0] d32;
  logic        in_valid8, in_ready8, out_valid8;
  logic [7:0]  d8;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp;

  always #5 clk = ~clk;

  alu_mdu #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
    .opcode(opcode), .a(a), .b(b), .kill(kill), .out_valid(out_valid32),
    .out_ready(out_ready), .d(d32)
  );

  alu_mdu #(.XLEN(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .opcode(opcode), .a(a[7:0]), .b(b[7:0]), .kill(kill), .out_valid(out_valid8),
    .out_ready(out_ready), .d(d8)
  );

  // Count one comparison and report it if it does not hold.
  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 8) ? in_ready8 : in_ready32;
  endfunction

  function automatic logic vld(input int w);
    return (w == 8) ? out_valid8 : out_valid32;
  endfunction

  function automatic logic [63:0] dout(input int w);
    if (w == 8) return {56'd0, d8};
    else        return {32'd0, d32};
  endfunction

  // Reference model built on 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] xi,
                                        input logic [63:0] yi, input int w);
    logic [63:0] m, x, y, r;
    longint      sx, sy, ux, uy;
    int          sh;
    m  = (64'd1 << w) - 64'd1;
    x  = xi & m;
    y  = yi & m;
    sx = x[w-1] ? longint'(x | ~m) : longint'(x);
    sy = y[w-1] ? longint'(y | ~m) : longint'(y);
    ux = longint'(x);
    uy = longint'(y);
    sh = int'(y & 64'(w - 1));
    if (!op[4]) begin
      case (op[2:0])
        3'd0: r = op[3] ? 64'(sx - sy) : 64'(sx + sy);
        3'd1: r = x << sh;
        3'd2: r = (sx < sy) ? 64'd1 : 64'd0;
        3'd3: r = (x < y) ? 64'd1 : 64'd0;
        3'd4: r = x ^ y;
        3'd5: r = op[3] ? 64'(sx >>> sh) : (x >> sh);
        3'd6: r = x | y;
        default: r = x & y;
      endcase
    end else begin
      case (op[2:0])
        3'd0: r = 64'(ux * uy);
        3'd1: r = 64'((sx * sy) >>> w);
        3'd2: r = 64'((sx * uy) >>> w);
        3'd3: r = 64'(ux * uy) >> w;
        3'd4: r = (y == 64'd0) ? m : 64'(sx / sy);
        3'd5: r = (y == 64'd0) ? m : 64'(ux / uy);
        3'd6: r = (y == 64'd0) ? x : 64'(sx % sy);
        default: r = (y == 64'd0) ? x : 64'(ux % uy);
      endcase
    end
    return r & m;
  endfunction

  // Wait for in_ready, present one request for exactly one accepting edge.
  task automatic issue(input int w, input logic [4:0] op, input logic [31:0] x,
                       input logic [31:0] y, input bit push, input logic [63:0] ex);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy(w) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_value("in_ready timeout", 64'd0, 64'd1);
    opcode = op;
    a      = x;
    b      = y;
    if (w == 8) in_valid8 = 1'b1;
    else        in_valid32 = 1'b1;
    if (push) exp_q.push_back(ex);
    @(posedge clk);
    #1;
    in_valid8  = 1'b0;
    in_valid32 = 1'b0;
  endtask

  // Count cycles from acceptance to out_valid and pop/compare the expected result.
  task automatic wait_valid(input int w, input int exp_lat, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vld(w) && n < 200);
    check_value({tag, " latency"}, 64'(n), 64'(exp_lat));
    if (exp_q.size() == 0) begin
      check_value({tag, " scoreboard empty"}, 64'd0, 64'd1);
    end else begin
      last_exp = exp_q.pop_front();
      check_value(tag, dout(w), last_exp);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input int w, input logic [4:0] op, input logic [31:0] x,
                     input logic [31:0] y, input logic [63:0] ex, input string tag);
    issue(w, op, x, y, 1'b1, ex);
    wait_valid(w, op[4] ? (w + 2) : 1, tag);
    release_out();
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 8) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return m;
      3:       return 32'd1 << (w - 1);
      default: return $urandom & m;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seen;
    logic [4:0]  rop;
    logic [31:0] rx, ry;

    reset = 1'b1; kill = 1'b0; out_ready = 1'b0;
    in_valid32 = 1'b0; in_valid8 = 1'b0;
    opcode = 5'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_value("reset in_ready", {63'd0, in_ready32}, 64'd1);
    check_value("reset out_valid", {63'd0, out_valid32}, 64'd0);
    check_value("reset d", {32'd0, d32}, 64'd0);

    // Base ops
    run(32, 5'b00000, 32'h7FFF_FFFF, 32'd1, 64'h8000_0000, "ADD ovf");
    run(32, 5'b01000, 32'd0, 32'd1, 64'hFFFF_FFFF, "SUB 0-1");
    run(32, 5'b01101, 32'h8000_0000, 32'd4, 64'hF800_0000, "SRA");
    run(32, 5'b00101, 32'h8000_0000, 32'd4, 64'h0800_0000, "SRL");
    run(32, 5'b00010, 32'hFFFF_FFFF, 32'd1, 64'd1, "SLT -1<1");
    run(32, 5'b00011, 32'hFFFF_FFFF, 32'd1, 64'd0, "SLTU");

    // Multiply
    run(32, 5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, "MULH -1*-1");
    run(32, 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE, "MULHU");
    run(32, 5'b10000, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFEB, "MUL 7*-3");
    run(32, 5'b10010, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF, "MULHSU -1*2");

    // Divide / remainder with special cases
    run(32, 5'b10100, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFD, "DIV -7/2");
    run(32, 5'b10110, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF, "REM -7%2");
    run(32, 5'b10101, 32'd5, 32'd0, 64'hFFFF_FFFF, "DIVU 5/0");
    run(32, 5'b10111, 32'd5, 32'd0, 64'd5, "REMU 5%0");
    run(32, 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000, "DIV ovf");
    run(32, 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, "REM ovf");
    run(32, 5'b10100, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFFF, "DIV -7/0");
    run(32, 5'b10110, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9, "REM -7%0");

    // Backpressure: result held, new request ignored while in DONE
    issue(32, 5'b10100, 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFF_FFFD);
    wait_valid(32, 34, "DIV bp");
    opcode = 5'b00000; a = 32'd1; b = 32'd1; in_valid32 = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_value("bp d stable", {32'd0, d32}, last_exp);
      check_value("bp in_ready", {63'd0, in_ready32}, 64'd0);
      check_value("bp out_valid", {63'd0, out_valid32}, 64'd1);
    end
    in_valid32 = 1'b0;
    release_out();
    check_value("bp in_ready after", {63'd0, in_ready32}, 64'd1);
    check_value("bp ignored req", {63'd0, out_valid32}, 64'd0);

    // Kill during BUSY
    issue(32, 5'b10101, 32'd1000, 32'd3, 1'b0, 64'd0);
    repeat (5) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check_value("kill in_ready", {63'd0, in_ready32}, 64'd1);
    check_value("kill out_valid", {63'd0, out_valid32}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid32) seen++;
    end
    check_value("kill no pulse", 64'(seen), 64'd0);
    run(32, 5'b10101, 32'd100, 32'd7, 64'd14, "DIVU 100/7");

    // Kill together with in_valid in IDLE: nothing accepted
    @(negedge clk);
    opcode = 5'b00000; a = 32'd1; b = 32'd2; in_valid32 = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1;
    in_valid32 = 1'b0; kill = 1'b0;
    check_value("kill+valid in_ready", {63'd0, in_ready32}, 64'd1);
    check_value("kill+valid out_valid", {63'd0, out_valid32}, 64'd0);

    // Reset mid-DIV (with kill also asserted)
    issue(32, 5'b10100, 32'hFFFF_FF9C, 32'd7, 1'b0, 64'd0);
    repeat (10) @(negedge clk);
    reset = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; kill = 1'b0;
    check_value("rst busy out_valid", {63'd0, out_valid32}, 64'd0);
    check_value("rst busy d", {32'd0, d32}, 64'd0);
    check_value("rst busy in_ready", {63'd0, in_ready32}, 64'd1);
    run(32, 5'b10100, 32'hFFFF_FF9C, 32'd7, 64'hFFFF_FFF2, "DIV -100/7 after rst");

    // Reset while holding a result in DONE
    issue(32, 5'b00000, 32'd3, 32'd4, 1'b1, 64'd7);
    wait_valid(32, 1, "ADD before rst");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_value("rst done out_valid", {63'd0, out_valid32}, 64'd0);
    check_value("rst done d", {32'd0, d32}, 64'd0);
    check_value("rst done in_ready", {63'd0, in_ready32}, 64'd1);

    // Randomized comparison against the model at both widths
    for (int i = 0; i < 40; i++) begin
      rop = 5'($urandom_range(0, 31));
      rx  = pick(32);
      ry  = pick(32);
      run(32, rop, rx, ry, model(rop, {32'd0, rx}, {32'd0, ry}, 32), "rand32");
    end
    for (int i = 0; i < 40; i++) begin
      rop = 5'($urandom_range(0, 31));
      rx  = pick(8);
      ry  = pick(8);
      run(8, rop, rx, ry, model(rop, {32'd0, rx}, {32'd0, ry}, 8), "rand8");
    end
    check_value("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
